// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter: FSM states,
// pending-read owner encodings and the starvation counter width.
package dmem_arbiter_pkg;

  typedef enum logic {
    PRIO_CORE = 1'b0,
    PRIO_DBG  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CORE = 2'd1,
    DBG  = 2'd2
  } owner_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, secondary port and RAM port of the arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface dmem_arbiter_if #(parameter int MEM = 10);

  logic            c_req;
  logic            c_we;
  logic [MEM-1:0]  c_addr;
  logic [31:0]     c_din;
  logic            c_gnt;
  logic            c_rvalid;
  logic [31:0]     c_rdata;

  logic            d_req;
  logic            d_we;
  logic [MEM-1:0]  d_addr;
  logic [31:0]     d_din;
  logic            d_gnt;
  logic            d_rvalid;
  logic [31:0]     d_rdata;

  logic            ram_we;
  logic [MEM-1:0]  ram_addr;
  logic [31:0]     ram_din;
  logic [31:0]     ram_dout;

  modport slave (
    input  c_req, c_we, c_addr, c_din,
    input  d_req, d_we, d_addr, d_din,
    input  ram_dout,
    output c_gnt, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output ram_we, ram_addr, ram_din
  );

  modport master (
    output c_req, c_we, c_addr, c_din,
    output d_req, d_we, d_addr, d_din,
    output ram_dout,
    input  c_gnt, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the secondary requester was denied.
// at_limit flags the denial that brings the count up to MAX_WAIT-1.
module dmem_arb_starve_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LIMIT) ? cnt : cnt + CNT_W'(1);
  end

  // Flagged one cycle early so the secondary wins on the cycle the count lands on the limit
  assign at_limit = inc && !clr && (cnt_next == LIMIT);

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt_next;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the core and the debug/dump engine.
// Define DMEM_ARB_RR_EN for strict alternation on contention instead of core priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM      = 10,
  parameter int MAX_WAIT = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_t state;
  owner_t owner;
  logic   c_gnt;
  logic   d_gnt;

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (state == PRIO_CORE) begin
        if (bus.c_req)      c_gnt = 1'b1;
        else if (bus.d_req) d_gnt = 1'b1;
      end else begin
        if (bus.d_req)      d_gnt = 1'b1;
        else if (bus.c_req) c_gnt = 1'b1;
      end
    end
  end

  assign bus.c_gnt = c_gnt;
  assign bus.d_gnt = d_gnt;

  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = {MEM{1'b0}};
    bus.ram_din  = 32'd0;
    if (c_gnt) begin
      bus.ram_we   = bus.c_we;
      bus.ram_addr = bus.c_addr;
      bus.ram_din  = bus.c_din;
    end else if (d_gnt) begin
      bus.ram_we   = bus.d_we;
      bus.ram_addr = bus.d_addr;
      bus.ram_din  = bus.d_din;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // state names who wins the next contended cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIO_CORE;
    end else if (bus.c_req && bus.d_req) begin
      state <= c_gnt ? PRIO_DBG : PRIO_CORE;
    end
  end
`else
  logic at_limit;

  dmem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (bus.d_req && !d_gnt),
    .clr      (!bus.d_req || d_gnt),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PRIO_CORE;
    end else begin
      case (state)
        PRIO_CORE: if (bus.c_req && bus.d_req && at_limit) state <= PRIO_DBG;
        PRIO_DBG:  if (d_gnt || !bus.d_req) state <= PRIO_CORE;
        default:   state <= PRIO_CORE;
      endcase
    end
  end
`endif

  // Owner of the read issued this cycle; its data comes back from the RAM next cycle
  always_ff @(posedge clk) begin
    if (rst)                     owner <= NONE;
    else if (c_gnt && !bus.c_we) owner <= CORE;
    else if (d_gnt && !bus.d_we) owner <= DBG;
    else                         owner <= NONE;
  end

  assign bus.c_rvalid = !rst && (owner == CORE);
  assign bus.d_rvalid = !rst && (owner == DBG);
  assign bus.c_rdata  = bus.ram_dout;
  assign bus.d_rdata  = bus.ram_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle grant/RAM-port checks plus a
// read-response scoreboard fed from a shadow copy of RAM contents.
module tb_dmem_arbiter;

  localparam int MEM = 10;

  logic clk;
  logic rst;

  dmem_arbiter_if #(.MEM(MEM)) bus ();

  dmem_arbiter #(.MEM(MEM), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram    [0:(1<<MEM)-1];
  logic [31:0] shadow [0:(1<<MEM)-1];

  // Behavioural single-port RAM with one cycle of read latency
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_addr];
  end

  typedef struct {
    logic        is_dbg;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t sb[$];
  int    cyc;
  int    total;
  int    bad;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  // One clock: check responses due now, grants and RAM port, then advance
  task automatic applyStimulus(input logic exp_c, input logic exp_d);
    resp_t       r;
    logic        ec;
    logic        ed;
    logic [31:0] edat;
    if (rst) sb.delete();
    @(negedge clk);
    ec   = 1'b0;
    ed   = 1'b0;
    edat = 32'd0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r    = sb.pop_front();
      ec   = !r.is_dbg;
      ed   = r.is_dbg;
      edat = r.data;
    end
    checkOutput("c_rvalid", 32'(bus.c_rvalid), 32'(ec));
    checkOutput("d_rvalid", 32'(bus.d_rvalid), 32'(ed));
    if (ec) checkOutput("c_rdata", bus.c_rdata, edat);
    if (ed) checkOutput("d_rdata", bus.d_rdata, edat);
    checkOutput("c_gnt", 32'(bus.c_gnt), 32'(exp_c));
    checkOutput("d_gnt", 32'(bus.d_gnt), 32'(exp_d));
    if (exp_c) begin
      checkOutput("ram_we_c", 32'(bus.ram_we), 32'(bus.c_we));
      checkOutput("ram_addr_c", 32'(bus.ram_addr), 32'(bus.c_addr));
      if (bus.c_we) begin
        checkOutput("ram_din_c", bus.ram_din, bus.c_din);
        shadow[bus.c_addr] = bus.c_din;
      end else begin
        sb.push_back('{1'b0, shadow[bus.c_addr], cyc + 1});
      end
    end else if (exp_d) begin
      checkOutput("ram_we_d", 32'(bus.ram_we), 32'(bus.d_we));
      checkOutput("ram_addr_d", 32'(bus.ram_addr), 32'(bus.d_addr));
      if (bus.d_we) begin
        checkOutput("ram_din_d", bus.ram_din, bus.d_din);
        shadow[bus.d_addr] = bus.d_din;
      end else begin
        sb.push_back('{1'b1, shadow[bus.d_addr], cyc + 1});
      end
    end else begin
      checkOutput("ram_we_idle", 32'(bus.ram_we), 32'd0);
      checkOutput("ram_addr_idle", 32'(bus.ram_addr), 32'd0);
      checkOutput("ram_din_idle", bus.ram_din, 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < (1 << MEM); i++) begin
      ram[i]    = 32'(i) * 32'h0101_0101;
      shadow[i] = 32'(i) * 32'h0101_0101;
    end
    ram[10'h010]    = 32'hDEAD_BEEF;
    shadow[10'h010] = 32'hDEAD_BEEF;

    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 10'h004; bus.c_din = 32'd0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h008; bus.d_din = 32'd0;
    rst = 1'b1;

    $display("[TB] reset with both requesters active");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0);

    $display("[TB] core read");
    bus.d_req = 1'b0; bus.c_addr = 10'h010;
    applyStimulus(1'b1, 1'b0);
    bus.c_req = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] starvation bound under continuous contention");
    bus.c_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 10'h010;
    for (int k = 1; k <= 24; k++) begin
      bus.c_addr = 10'(k + 32);
`ifdef DMEM_ARB_RR_EN
      applyStimulus(k % 2 == 0, k % 2 == 1);
`else
      applyStimulus(k % 8 != 0, k % 8 == 0);
`endif
    end
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    applyStimulus(1'b0, 1'b0);

    $display("[TB] core write then secondary read of the same word");
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 10'h020; bus.c_din = 32'h1234_5678;
    applyStimulus(1'b1, 1'b0);
    bus.c_req = 1'b0; bus.c_we = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h020;
    applyStimulus(1'b0, 1'b1);
    bus.d_req = 1'b0;
    applyStimulus(1'b0, 1'b0);

    $display("[TB] secondary write, then read back");
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h031; bus.d_din = 32'hA5A5_0F0F;
    applyStimulus(1'b0, 1'b1);
    bus.d_we = 1'b0;
    applyStimulus(1'b0, 1'b1);
    bus.d_req = 1'b0;
    applyStimulus(1'b0, 1'b0);

    $display("[TB] reset arriving the cycle after a secondary read");
    bus.d_req = 1'b1; bus.d_addr = 10'h020;
    applyStimulus(1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    bus.c_req = 1'b1; bus.c_addr = 10'h010;
    applyStimulus(1'b1, 1'b0);
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
